// File: rtl/digit_scan_ctrl.sv
// Frame controller for a 4-digit multiplexed 7-segment display: snapshots the
// time, fills four BCD digit registers via a shared splitter, then scans anodes.
module digit_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] hours,
  input  logic [7:0] minutes,
  input  logic [7:0] seconds,
  input  logic       page,
  input  logic [1:0] blink_field,
  input  logic       blink_tick,
  output logic [7:0] split_total,
  input  logic [3:0] split_left,
  input  logic [3:0] split_right,
  output logic [3:0] digit_val,
  output logic [3:0] an,
  output logic       dp,
  output logic       frame_done
);

  localparam int unsigned CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [3:0] BLANK = 4'hF;

  typedef enum logic [1:0] {
    SNAP   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2,
    SCAN   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    slot_q, slot_d;
  logic [7:0]    hours_q, hours_d, minutes_q, minutes_d, seconds_q, seconds_d;
  logic          page_q, page_d;
  logic [1:0]    blink_q, blink_d;
  logic          phase_q, phase_d;
  logic [3:0]    d3_q, d3_d, d2_q, d2_d, d1_q, d1_d, d0_q, d0_d;
  logic [7:0]    split_q, split_d;
  logic [3:0]    an_q, an_d;
  logic          dp_q, dp_d;
  logic [3:0]    digit_q, digit_d;
  logic          frame_done_q, frame_done_d;
  logic [3:0]    slot_digit_s;
  logic          field_ok_s;
  logic          blank_s;

  // Legal range of a displayed field; 60 is rejected even though the splitter accepts it.
  function automatic logic field_in_range(input logic [7:0] value, input logic is_hours);
    if (is_hours) begin
      field_in_range = (value <= 8'd23);
    end else begin
      field_in_range = (value <= 8'd59);
    end
  endfunction

  assign split_total = split_q;
  assign digit_val   = digit_q;
  assign an          = an_q;
  assign dp          = dp_q;
  assign frame_done  = frame_done_q;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    slot_d       = slot_q;
    hours_d      = hours_q;
    minutes_d    = minutes_q;
    seconds_d    = seconds_q;
    page_d       = page_q;
    blink_d      = blink_q;
    phase_d      = phase_q ^ blink_tick;
    d3_d         = d3_q;
    d2_d         = d2_q;
    d1_d         = d1_q;
    d0_d         = d0_q;
    split_d      = split_q;
    an_d         = 4'b1111;
    dp_d         = 1'b1;
    digit_d      = BLANK;
    frame_done_d = 1'b0;
    field_ok_s   = 1'b0;
    blank_s      = 1'b0;

    case (slot_q)
      2'd3:    slot_digit_s = d3_q;
      2'd2:    slot_digit_s = d2_q;
      2'd1:    slot_digit_s = d1_q;
      2'd0:    slot_digit_s = d0_q;
      default: slot_digit_s = BLANK;
    endcase

    case (state_q)
      SNAP: begin
        hours_d   = hours;
        minutes_d = minutes;
        seconds_d = seconds;
        page_d    = page;
        blink_d   = blink_field;
        split_d   = page ? minutes : hours;
        state_d   = LOAD_A;
      end
      LOAD_A: begin
        field_ok_s = page_q ? field_in_range(minutes_q, 1'b0) : field_in_range(hours_q, 1'b1);
        d3_d       = field_ok_s ? split_left  : BLANK;
        d2_d       = field_ok_s ? split_right : BLANK;
        split_d    = page_q ? seconds_q : minutes_q;
        state_d    = LOAD_B;
      end
      LOAD_B: begin
        field_ok_s = page_q ? field_in_range(seconds_q, 1'b0) : field_in_range(minutes_q, 1'b0);
        d1_d       = field_ok_s ? split_left  : BLANK;
        d0_d       = field_ok_s ? split_right : BLANK;
        cnt_d      = '0;
        slot_d     = 2'd3;
        state_d    = SCAN;
      end
      SCAN: begin
        // Slots 3/2 form the left pair (blink bit 1), slots 1/0 the right pair.
        blank_s = phase_q & blink_q[slot_q[1]];
        an_d    = blank_s ? 4'b1111 : ~(4'b0001 << slot_q);
        digit_d = blank_s ? BLANK : slot_digit_s;
        dp_d    = (slot_q != 2'd2);
        if (cnt_q == CNT_MAX) begin
          cnt_d = '0;
          if (slot_q == 2'd0) begin
            slot_d       = 2'd3;
            frame_done_d = 1'b1;
            state_d      = SNAP;
          end else begin
            slot_d = slot_q - 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = SNAP;
      end
    endcase
  end

  // State, shadow, digit and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SNAP;
      cnt_q        <= '0;
      slot_q       <= 2'd3;
      hours_q      <= 8'd0;
      minutes_q    <= 8'd0;
      seconds_q    <= 8'd0;
      page_q       <= 1'b0;
      blink_q      <= 2'b00;
      phase_q      <= 1'b0;
      d3_q         <= BLANK;
      d2_q         <= BLANK;
      d1_q         <= BLANK;
      d0_q         <= BLANK;
      split_q      <= 8'd0;
      an_q         <= 4'b1111;
      dp_q         <= 1'b1;
      digit_q      <= BLANK;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      slot_q       <= slot_d;
      hours_q      <= hours_d;
      minutes_q    <= minutes_d;
      seconds_q    <= seconds_d;
      page_q       <= page_d;
      blink_q      <= blink_d;
      phase_q      <= phase_d;
      d3_q         <= d3_d;
      d2_q         <= d2_d;
      d1_q         <= d1_d;
      d0_q         <= d0_d;
      split_q      <= split_d;
      an_q         <= an_d;
      dp_q         <= dp_d;
      digit_q      <= digit_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: doc/digit_scan_ctrl.md
# digit_scan_ctrl

Time-multiplexing controller for the clock's 4-digit 7-segment display. Each frame it captures a coherent snapshot of hours, minutes and seconds. It then runs the shared tens/units splitter twice, once per displayed field, to fill four BCD digit registers. Finally it scans the four anodes at a fixed refresh rate. It sits between the timekeeping counters and the splitter/7-segment decoder, and it owns all anode, colon and blink sequencing.

## Interface
- REFRESH_DIV, 50000: clock cycles per digit slot (1 kHz digit rate at 50 MHz); legal range ≥ 2.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- hours  in  8  binary hours, legal 0–23.
- minutes  in  8  binary minutes, legal 0–59.
- seconds  in  8  binary seconds, legal 0–59.
- page  in  1  0 selects HH:MM, 1 selects MM:SS.
- blink_field  in  2  bit1 selects blinking of the left pair; bit0 selects blinking of the right pair.
- blink_tick  in  1  one-cycle pulse; toggles the blink phase.
- split_total  out  8  operand driven to the shared splitter.
- split_left  in  4  splitter tens result (combinational from split_total).
- split_right  in  4  splitter units result.
- digit_val  out  4  BCD for the decoder; 4'hF means blank.
- an  out  4  anodes, active-low; an[3] is the leftmost digit.
- dp  out  1  colon/decimal point, active-low.
- frame_done  out  1  one-cycle pulse per completed frame.

## Operation
- FSM states:
  - SNAP → LOAD_A → LOAD_B → SCAN. SCAN returns to SNAP after the last slot.
  - Reset state is SNAP.
- SNAP (1 cycle):
  - Register hours, minutes, seconds, page and blink_field into shadow registers.
  - Load split_total with field A: hours if page=0, minutes if page=1.
- LOAD_A (1 cycle):
  - Latch split_left into d3 and split_right into d2.
  - Load split_total with field B: minutes if page=0, seconds if page=1.
- LOAD_B (1 cycle): latch split_left into d1 and split_right into d0.
- Range check at latch time:
  - Applies to the shadow value of the field being latched.
  - Hours > 23 or minutes/seconds > 59 sets both digits of that pair to 4'hF.
  - The value 60 is illegal here even though the splitter accepts it.
- SCAN:
  - Four slots in order k=3,2,1,0, each REFRESH_DIV cycles.
  - A slot counter counts 0..REFRESH_DIV-1 and wraps at the slot boundary.
  - At the end of slot 0, the next state is SNAP.
- Display drive in slot k:
  - an = all ones except bit k low.
  - digit_val = dk.
  - dp = 0 only in slot 2 (colon between the pairs); otherwise 1.
- Blink:
  - blink_phase toggles on every blink_tick, in any state.
  - When blink_phase=1 and the shadow blink bit for a pair is set, that pair's anodes stay 1 and its digit_val is 4'hF.
  - dp is unaffected by blink.
- Overhead states (SNAP, LOAD_A, LOAD_B): an=4'b1111, dp=1, digit_val=4'hF, which prevents ghosting.
- Live inputs are ignored outside SNAP. A pair's digits change only at a frame boundary.

## Timing
- an, dp, digit_val and frame_done are registered. Each reflects the state/slot of the previous cycle.
- Frame length is exactly 3 + 4·REFRESH_DIV cycles.
- Splitter path:
  - split_total is valid in the cycle after SNAP and the cycle after LOAD_A.
  - The splitter is combinational; no wait states are added.
- frame_done:
  - Asserted for exactly one cycle, in the cycle after the last cycle of slot 0.
  - That is the same cycle the FSM occupies SNAP.
  - Never asserted during the first frame after reset.
- Reset values (immediate on rst_n=0, including mid-scan):
  - an=4'b1111, dp=1, digit_val=4'hF, split_total=0, frame_done=0.
  - d3..d0=4'hF, blink_phase=0, slot counter=0, state=SNAP.
- After rst_n deasserts, SNAP runs on the first rising edge.
- blink_tick coincident with a slot boundary: the toggle and the boundary both take effect. The new phase applies to the new slot.
- blink_tick held high: toggles every cycle (level-sampled, no edge detect).

## Test plan
- REFRESH_DIV=4, hours=12, minutes=34, page=0, no blink:
  - Frame is 19 cycles.
  - Slots show an=0111/1011/1101/1110 with digit_val=1,2,3,4, each held 4 cycles.
  - dp=0 only in slot 2.
  - frame_done pulses once per 19 cycles.
- page=1, minutes=59, seconds=0 -> digits 5,9,0,0. minutes changed to 7 mid-scan -> current frame keeps 5,9; next frame shows 0,7.
- hours=24 or minutes=60 -> that pair shows 4'hF,4'hF; the other pair is correct.
- blink_field=2'b10, one blink_tick:
  - Slots 3 and 2 are blanked (an bits high, digit_val=F).
  - Slots 1 and 0 are normal.
  - A second tick restores display from the next slot.
- Assert rst_n low in slot 1 -> the same cycle shows an=1111, dp=1, digit_val=F. On release, the first frame restarts at SNAP.
- Check split_total sequence: 0 after reset, then hours, then minutes, across the SNAP/LOAD_A cycles with page=0.
